riscv_step_controller: RTL and testbench

//  Execution sequencer for RISCVProcessor: gates the core's clock-enable (cpu_en).

---
 rtl/riscv_step_controller.sv | 114 +++++++++++
 tb/tb_riscv_step_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_step_controller.sv
// Execution sequencer for the RISC-V core: gates cpu_en for debounced single-step
// presses or free-run with a PC breakpoint, and counts executed instructions.
module riscv_step_controller #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int PC_W            = 32,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             CLK_BUTT,
    input  logic             run_mode,
    input  logic             bp_enable,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic             halted,
    output logic [CNT_W-1:0] step_count,
    output logic [2:0]       state
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_STEP     = 3'd2,
        S_WAIT_REL = 3'd3,
        S_RUN      = 3'd4,
        S_HALTED   = 3'd5
    } state_t;

    state_t          st, st_nxt;
    logic [DB_W-1:0] db_cnt, db_cnt_nxt;
    logic [1:0]      sync_q;
    logic            btn_s;
    logic            bp_hit;

    // Two-flop synchronizer; the raw button is never looked at past this point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], CLK_BUTT};
    end

    assign btn_s  = sync_q[1];
    assign bp_hit = bp_enable & (pc == bp_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= S_IDLE;
            db_cnt <= '0;
        end else begin
            st     <= st_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    always_comb begin
        st_nxt     = st;
        db_cnt_nxt = db_cnt;
        case (st)
            S_IDLE: begin
                if (run_mode) begin
                    st_nxt = S_RUN;
                end else if (btn_s) begin
                    st_nxt     = S_DEBOUNCE;
                    db_cnt_nxt = '0;
                end
            end
            S_DEBOUNCE: begin
                if (!btn_s)                 st_nxt     = S_IDLE;
                else if (db_cnt == DB_LAST) st_nxt     = S_STEP;
                else                        db_cnt_nxt = db_cnt + DB_W'(1);
            end
            S_STEP: begin
                st_nxt     = S_WAIT_REL;
                db_cnt_nxt = '0;
            end
            // A held button keeps restarting the release count, so it can never re-step.
            S_WAIT_REL: begin
                if (btn_s)                  db_cnt_nxt = '0;
                else if (db_cnt == DB_LAST) st_nxt     = S_IDLE;
                else                        db_cnt_nxt = db_cnt + DB_W'(1);
            end
            S_RUN: begin
                if (!run_mode)   st_nxt = S_IDLE;
                else if (bp_hit) st_nxt = S_HALTED;
            end
            S_HALTED: begin
                if (!run_mode) begin
                    st_nxt = S_IDLE;
                end else if (btn_s) begin
                    st_nxt     = S_DEBOUNCE;
                    db_cnt_nxt = '0;
                end
            end
            default: begin
                st_nxt     = S_IDLE;
                db_cnt_nxt = '0;
            end
        endcase
    end

    // Combinational bp_hit term keeps the breakpoint instruction from executing in run mode.
    assign cpu_en = (st == S_STEP) | ((st == S_RUN) & ~bp_hit & run_mode);
    assign halted = (st == S_HALTED);
    assign state  = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      step_count <= '0;
        else if (cpu_en) step_count <= step_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_riscv_step_controller.sv
// Scoreboard bench: stimulus predicts each cpu_en pulse (cycle, count); a negedge monitor checks them.
module tb_riscv_step_controller;

    localparam int D     = 2;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             CLK_BUTT = 1'b0;
    logic             run_mode = 1'b0;
    logic             bp_enable = 1'b0;
    logic [PC_W-1:0]  bp_addr = '0;
    logic [PC_W-1:0]  pc = '0;
    logic             pc_clr = 1'b0;
    logic             cpu_en;
    logic             halted;
    logic [CNT_W-1:0] step_count;
    logic [2:0]       state;

    typedef struct { int cyc; int cnt; } ev_t;
    ev_t sb[$];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    riscv_step_controller #(.DEBOUNCE_CYCLES(D), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .CLK_BUTT(CLK_BUTT), .run_mode(run_mode),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
        .halted(halted), .step_count(step_count), .state(state)
    );

    always #5 clk = ~clk;

    // Cycle index plus a trivial core: pc advances by one instruction per enabled cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pc_clr)      pc <= '0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c);
        ev_t e;
        e.cyc = c;
        e.cnt = exp_cnt;
        sb.push_back(e);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    // A press stable for more than D synced cycles yields one step, 3+D cycles after the rise.
    task automatic press(input int len, input int gap);
        int d;
        d = cyc;
        if (len >= D + 1) push(d + 3 + D);
        CLK_BUTT = 1'b1;
        tick(len);
        CLK_BUTT = 1'b0;
        tick(gap);
    endtask

    // Free-run from the current pc into a breakpoint k instructions ahead, then step over it.
    task automatic run_bp(input int k, input int r);
        int c, d, s;
        c = cyc;
        for (int i = 1; i <= k; i++) push(c + i);
        run_mode = 1'b1;
        tick(k + 1);
        chk("bp_cycle_cpu_en", int'(cpu_en), 0);
        chk("bp_cycle_halted", int'(halted), 0);
        tick(1);
        chk("halted_flag", int'(halted), 1);
        chk("halted_state", int'(state), 5);
        tick(3);
        chk("halted_hold", int'(halted), 1);
        d = cyc;
        push(d + 3 + D);
        CLK_BUTT = 1'b1;
        tick(6);
        CLK_BUTT = 1'b0;
        s = cyc;
        for (int i = 0; i < r; i++) push(s + 3 + D + i);
        tick(3 + D + r);
        run_mode = 1'b0;
        tick(D + 4);
        chk("run_exit_state", int'(state), 0);
        chk("run_exit_halted", int'(halted), 0);
    endtask

    // run_mode drops on the very cycle the breakpoint matches: back to idle, not halted.
    task automatic run_bp_drop(input int k);
        int c;
        c = cyc;
        for (int i = 1; i <= k; i++) push(c + i);
        run_mode = 1'b1;
        tick(k + 1);
        run_mode = 1'b0;
        tick(1);
        chk("drop_state", int'(state), 0);
        chk("drop_halted", int'(halted), 0);
    endtask

    always @(negedge clk) begin
        if (cpu_en === 1'b1) begin
            ev_t e;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_step: cpu_en=1 at cycle %0d, none expected", cyc);
            end else begin
                e = sb.pop_front();
                chk("step_cycle", cyc, e.cyc);
                chk("step_count_at_pulse", int'(step_count), e.cnt);
            end
        end
    end

    initial begin
        int len, gap, k;

        tick(3);
        chk("rst_cpu_en", int'(cpu_en), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_step_count", int'(step_count), 0);
        chk("rst_state", int'(state), 0);
        reset = 1'b1;
        tick(3);

        // Single clean press.
        press(8, 10);
        chk("single_state", int'(state), 0);
        chk("single_count", int'(step_count), 1);

        // One-cycle glitches never step.
        repeat (5) press(1, 2);
        tick(5);
        chk("bounce_count", int'(step_count), 1);

        // Long hold gives one step; a second press gives another.
        press(100, D + 4);
        press(8, 10);
        chk("hold_count", int'(step_count), exp_cnt);

        // Random mix of glitches and real presses.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) len = $urandom_range(1, D);
            else                           len = $urandom_range(D + 1, D + 30);
            gap = $urandom_range(D, D + 6);
            press(len, gap);
        end
        tick(10);
        chk("random_state", int'(state), 0);
        chk("random_count", int'(step_count), exp_cnt);
        chk("random_pending", sb.size(), 0);

        // Run into breakpoint at 0x10 from pc 0, step over, resume, stop.
        pc_clr = 1'b1;
        tick(1);
        pc_clr = 1'b0;
        bp_enable = 1'b1;
        bp_addr = 32'h10;
        run_bp(4, 7);
        for (int i = 0; i < 4; i++) begin
            k = $urandom_range(1, 8);
            bp_addr = pc + 32'(4 * k);
            if (i % 2 == 0) run_bp(k, $urandom_range(3, 12));
            else            run_bp_drop(k);
        end
        bp_enable = 1'b0;
        tick(4);
        chk("bp_pending", sb.size(), 0);

        // Asynchronous reset in the middle of a debounce.
        CLK_BUTT = 1'b1;
        tick(4);
        chk("mid_debounce_state", int'(state), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_cpu_en", int'(cpu_en), 0);
        chk("async_rst_halted", int'(halted), 0);
        chk("async_rst_count", int'(step_count), 0);
        chk("async_rst_state", int'(state), 0);
        exp_cnt = 0;
        CLK_BUTT = 1'b0;
        tick(3);
        #3 reset = 1'b1;
        tick(20);
        chk("post_rst_state", int'(state), 0);
        chk("post_rst_count", int'(step_count), 0);

        // 17 run cycles with a 4-bit counter wraps to 1.
        k = cyc;
        for (int i = 1; i <= 17; i++) push(k + i);
        run_mode = 1'b1;
        tick(18);
        run_mode = 1'b0;
        tick(3);
        chk("wrap_count", int'(step_count), 1);

        tick(5);
        chk("final_pending", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
